// File: rtl/mdsa_pkg.sv
// Shared constants for the MDSA sorter arbiter: state encodings, default sizes
// and the sorter length.
package mdsa_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LAUNCH = 3'd1;
    localparam logic [2:0] ST_ACK    = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam int NREQ_DEF    = 4;
    localparam int TIMEOUT_DEF = 255;
    localparam int SORT_LEN    = 16;

endpackage

// File: rtl/mdsa_rr_picker.sv
// Combinational round-robin pick: first set req bit scanning owner+1, owner+2, ...
// mod NREQ. Returns the one-hot winner, its index and whether any bit was set.
module mdsa_rr_picker #(
    parameter int NREQ  = 4,
    parameter int OWN_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [OWN_W-1:0] owner,
    output logic [NREQ-1:0]  win,
    output logic [OWN_W-1:0] win_idx,
    output logic             any
);

    always_comb begin
        int p;
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        p       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            p = (int'(owner) + k) % NREQ;
            if (!any && req[p]) begin
                any     = 1'b1;
                win[p]  = 1'b1;
                win_idx = OWN_W'(p);
            end
        end
    end

endmodule

// File: rtl/mdsa_sort_arbiter.sv
// Round-robin arbiter sharing one MDSA bitonic sorter between NREQ requesters.
// Define MDSA_ARB_TIMEOUT_EN to abort jobs whose sort_oe never arrives.
module mdsa_sort_arbiter
    import mdsa_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int OWN_W   = 2,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int TO_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [OWN_W-1:0] owner,
    output logic             busy,
    output logic [NREQ-1:0]  done,
    output logic [NREQ-1:0]  err,
    output logic             sort_start,
    input  logic             sort_ready,
    input  logic             sort_oe
);

    logic [2:0]       state;
    logic [NREQ-1:0]  win;
    logic [OWN_W-1:0] win_idx;
    logic             win_vld;

    mdsa_rr_picker #(.NREQ(NREQ), .OWN_W(OWN_W)) u_picker (
        .req     (req),
        .owner   (owner),
        .win     (win),
        .win_idx (win_idx),
        .any     (win_vld)
    );

    // An empty block that only exists when TO_W cannot hold TIMEOUT.
    if (TIMEOUT >= (1 << TO_W)) begin : g_to_w_too_narrow
    end

`ifdef MDSA_ARB_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
    wire             to_hit = (to_cnt == TO_W'(TIMEOUT - 1));
`else
    assign err = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            gnt        <= '0;
            done       <= '0;
            sort_start <= 1'b0;
            busy       <= 1'b0;
            owner      <= OWN_W'(NREQ - 1);
`ifdef MDSA_ARB_TIMEOUT_EN
            to_cnt     <= '0;
            err        <= '0;
`endif
        end else begin
            // Pulses default low; with en=0 the state holds so a pending pulse re-fires later.
            sort_start <= 1'b0;
            done       <= '0;
`ifdef MDSA_ARB_TIMEOUT_EN
            err        <= '0;
`endif
            if (en) begin
                case (state)
                    ST_IDLE: begin
                        if (win_vld && sort_ready) begin
                            gnt   <= win;
                            owner <= win_idx;
                            busy  <= 1'b1;
                            state <= ST_LAUNCH;
                        end
                    end
                    ST_LAUNCH: begin
                        sort_start <= 1'b1;
                        state      <= ST_ACK;
`ifdef MDSA_ARB_TIMEOUT_EN
                        to_cnt     <= '0;
`endif
                    end
                    ST_ACK, ST_RUN: begin
                        if (sort_oe) begin
                            done  <= gnt;
                            gnt   <= '0;
                            state <= ST_DONE;
`ifdef MDSA_ARB_TIMEOUT_EN
                        end else if (to_hit) begin
                            err   <= gnt;
                            gnt   <= '0;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
`endif
                        end else begin
                            if (state == ST_ACK && !sort_ready)
                                state <= ST_RUN;
`ifdef MDSA_ARB_TIMEOUT_EN
                            to_cnt <= to_cnt + 1'b1;
`endif
                        end
                    end
                    ST_DONE: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: begin
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
